// File: rtl/pong_vga_out_if.sv
// rtl/pong_vga_out_if.sv - pixel stream from the frame renderer into the VGA output stage
interface pong_vga_out_if;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_ready;

    modport master (output in_data, output in_valid, output in_sop, input in_ready);
    modport slave  (input in_data, input in_valid, input in_sop, output in_ready);
endinterface

// File: rtl/pong_vga_out.sv
// rtl/pong_vga_out.sv - buffered RGB444 pixel stream to 640x480@60 VGA conduit with frame realignment
module pong_vga_out #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    pong_vga_out_if.slave pix_in,
    input  logic         clear_underflow,
    output logic         underflow,
    output logic         frame_start,
    output logic         vga_CLK,
    output logic         vga_HS,
    output logic         vga_VS,
    output logic         vga_BLANK,
    output logic         vga_SYNC,
    output logic [3:0]   vga_R,
    output logic [3:0]   vga_G,
    output logic [3:0]   vga_B
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {RESYNC, RUN} state_t;

    state_t        state_q, state_d;
    logic          pix_en, rst_done;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [12:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic          head_sop;
    logic [11:0]   head_data;
    logic          visible, origin, err, start;
    logic [11:0]   rgb_d;

    assign full            = (wr_ptr - rd_ptr) == FIFO_FULL;
    assign empty           = wr_ptr == rd_ptr;
    assign pix_in.in_ready = rst_done && !full;
    assign push            = pix_in.in_valid && pix_in.in_ready;
    assign {head_sop, head_data} = mem[rd_ptr[AW-1:0]];
    assign visible         = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
    assign origin          = (h_cnt == '0) && (v_cnt == '0);
    assign vga_CLK         = pix_en;
    assign vga_SYNC        = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en   <= 1'b0;
            rst_done <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            pix_en   <= !pix_en;
            rst_done <= 1'b1;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {pix_in.in_sop, pix_in.in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= RESYNC;
        else          state_q <= state_d;
    end

    // RESYNC flushes stale pixels every clk but holds a start-of-frame pixel until the origin slot
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        err     = 1'b0;
        start   = 1'b0;
        rgb_d   = '0;
        case (state_q)
            RESYNC: begin
                if (!empty) begin
                    if (!head_sop) begin
                        pop = 1'b1;
                    end else if (pix_en && origin) begin
                        pop     = 1'b1;
                        start   = 1'b1;
                        rgb_d   = head_data;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (pix_en && visible) begin
                    if (empty || (head_sop && !origin)) begin
                        err     = 1'b1;
                        state_d = RESYNC;
                    end else begin
                        pop   = 1'b1;
                        start = origin;
                        rgb_d = head_data;
                    end
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_HS      <= 1'b1;
            vga_VS      <= 1'b1;
            vga_BLANK   <= 1'b0;
            vga_R       <= '0;
            vga_G       <= '0;
            vga_B       <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= pix_en && start;
            if (pix_en) begin
                vga_HS    <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
                vga_VS    <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
                vga_BLANK <= visible;
                {vga_R, vga_G, vga_B} <= rgb_d;
            end
            if (err)                  underflow <= 1'b1;
            else if (clear_underflow) underflow <= 1'b0;
        end
    end
endmodule
